fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Shares one `fpu` adder instance between `N_REQ` requesters through per-requester valid/ready request ports and one-hot response strobes. Arbitration is round-robin. The block latches the granted operand pair and presents it to the FPU for a fixed latency. It then captures result and status and returns them to the winning requester. It sits between the requesting datapath blocks and the FPU, and owns the FPU operand inputs exclusively.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `FPU_LAT`, 2: cycles from operands stable at the FPU to `fpu_data_in`/`fpu_status_in` valid, 1..15.
- `clock100KHz` in 1: the single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid_in` in N_REQ: request pending, one bit per requester.
- `req_op_a_in` in 32*N_REQ: operand A of requester i in bits [32i+31:32i]. Format: sign [31], exponent [30:25], mantissa [24:0].
- `req_op_b_in` in 32*N_REQ: operand B, same packing.
- `req_ready_out` out N_REQ: acceptance, at most one bit high.
- `rsp_valid_out` out N_REQ: one-cycle one-hot result strobe.
- `rsp_data_out` out 32: result word, valid with `rsp_valid_out`.
- `rsp_status_out` out 4: status, one-hot: [0] EXACT, [1] INEXACT, [2] OVERFLOW, [3] UNDERFLOW.
- `fpu_op_a_out` / `fpu_op_b_out` out 32 each: operands to the FPU.
- `fpu_data_in` in 32, `fpu_status_in` in 4: FPU result and status.
- `busy_out` out 1: high in any state other than IDLE.
- `grant_id_out` out $clog2(N_REQ): index of the current or last grantee.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid_in` bit is high, go to WAIT; otherwise stay.
  - WAIT: go to RESP after the wait counter expires.
  - RESP: go to IDLE after one cycle.
- Arbitration, in IDLE only, combinational:
  - Scan from `rr_ptr` upward with wrap to `N_REQ-1` -> 0.
  - The first index with valid high wins.
  - `req_ready_out[win]` = 1; all other ready bits are 0.
  - Ready is 0 in every other state.
- Acceptance happens on `valid && ready`:
  - Latch the winner's A/B into the operand registers.
  - Set `grant_id_out` = win.
  - Set `rr_ptr` = (win+1) mod `N_REQ`.
  - Load the wait counter with `FPU_LAT`.
- `fpu_op_*_out` are driven directly from the operand registers. They hold their value until the next acceptance.
- WAIT: the counter decrements each cycle. On the edge where it reaches 0, capture `fpu_data_in`/`fpu_status_in` into the response registers.
- RESP: `rsp_valid_out` is one-hot at `grant_id_out` for exactly one cycle. There is no response backpressure; a requester must sample the result in that cycle.
- Status passes through unmodified, including all-zero or multi-hot codes.
- A requester may drop valid before it is granted without side effect.
- A requester whose operation is in flight cannot be re-granted until IDLE.
- The `rr_ptr` update rule prevents starvation: each valid requester is served within `N_REQ` grants.

## Timing
- Reset values, with all outputs held at these while `reset` is high:
  - `req_ready_out`, `rsp_valid_out`, `rsp_data_out`, `rsp_status_out`, `fpu_op_*_out`, `busy_out`, `grant_id_out`, `rr_ptr`: all 0.
  - FSM: IDLE.
- Reset asserted mid-operation discards the in-flight operation. No response strobe is issued for it, and none is issued after release.
- Timing from acceptance in cycle T:
  - Operands at the FPU from T+1.
  - WAIT occupies T+1..T+`FPU_LAT`.
  - Capture occurs at the end of T+`FPU_LAT`.
  - `rsp_valid_out` is high in T+`FPU_LAT`+1.
  - The block is back in IDLE at T+`FPU_LAT`+2 and can accept again that same cycle.
- Throughput: one operation per `FPU_LAT`+2 cycles.
- `busy_out` is high T+1..T+`FPU_LAT`+1.
- Simultaneous requests: exactly one is accepted per IDLE cycle. The others wait with valid held.

## Configuration
- `FPU_ARB_STICKY_FLAGS_EN` defined:
  - Adds `sticky_clr_in` in 1 and `sticky_flags_out` out 3.
  - `sticky_flags_out` is {UNDERFLOW, OVERFLOW, INEXACT}, accumulated by OR on every RESP cycle. Reset value is 0.
  - `sticky_clr_in` high clears the flags on the next edge. If a clear and a RESP fall in the same cycle, the new flags of that RESP survive.
- `FPU_ARB_STICKY_FLAGS_EN` not defined: both ports and all related logic are absent.

## Test plan
- Single request, `FPU_LAT`=2; bench FPU model returns A+B one-hot-EXACT after 2 cycles:
  - Stimulus: req 1 with A=32'h0200_0010, B=32'h0200_0020 at T.
  - Required: `req_ready_out`=4'b0010 at T, `rsp_valid_out`=4'b0010 at T+3, `rsp_data_out`=32'h0400_0030, `rsp_status_out`=4'b0001.
- All four valid continuously from reset: grants occur in order 0,1,2,3,0, spaced 4 cycles apart, and no `req_ready_out` is ever multi-hot.
- Requesters 0 and 2 only, held valid: grants alternate 0,2,0,2. After granting 2, `rr_ptr` becomes 3 and then wraps to 0.
- `reset` pulsed for 1 cycle at T+1 after acceptance: all outputs are 0 immediately, no `rsp_valid_out` pulse ever appears, and the next grant goes to index 0.
- FPU model returns status 4'b0110 then 4'b1000, with the macro defined:
  - `sticky_flags_out` = 3'b011 after the first RESP, then 3'b111 after the second.
  - `sticky_clr_in` then gives 3'b000 on the next edge.
- Requester 3 raises valid for 1 cycle while the block is busy, then drops it: no grant and no response for 3.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU adder between N_REQ requesters.
// Optional sticky exception flags are enabled by defining FPU_ARB_STICKY_FLAGS_EN.
module fpu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FPU_LAT = 2
) (
    input  logic                       clock100KHz,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid_in,
    input  logic [32*N_REQ-1:0]        req_op_a_in,
    input  logic [32*N_REQ-1:0]        req_op_b_in,
    output logic [N_REQ-1:0]           req_ready_out,
    output logic [N_REQ-1:0]           rsp_valid_out,
    output logic [31:0]                rsp_data_out,
    output logic [3:0]                 rsp_status_out,
    output logic [31:0]                fpu_op_a_out,
    output logic [31:0]                fpu_op_b_out,
    input  logic [31:0]                fpu_data_in,
    input  logic [3:0]                 fpu_status_in,
`ifdef FPU_ARB_STICKY_FLAGS_EN
    input  logic                       sticky_clr_in,
    output logic [2:0]                 sticky_flags_out,
`endif
    output logic                       busy_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id_out
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [3:0]    rsp_status_q, rsp_status_d;

    logic [IW-1:0] win_idx;
    logic          any_valid;
    logic [IW:0]   scan_idx;
    logic [31:0]   op_a_arr [N_REQ];
    logic [31:0]   op_b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign op_a_arr[gi]      = req_op_a_in[32*gi +: 32];
            assign op_b_arr[gi]      = req_op_b_in[32*gi +: 32];
            assign req_ready_out[gi] = !reset && (state_q == IDLE) && any_valid
                                       && (win_idx == IW'(gi));
            assign rsp_valid_out[gi] = (state_q == RESP) && (grant_q == IW'(gi));
        end
    endgenerate

    // Scan upward from rr_ptr with wrap; the first valid index wins.
    always_comb begin
        win_idx   = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(N_REQ))
                scan_idx = scan_idx - (IW+1)'(N_REQ);
            if (!any_valid && req_valid_in[scan_idx[IW-1:0]]) begin
                any_valid = 1'b1;
                win_idx   = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d  = WAIT;
                    op_a_d   = op_a_arr[win_idx];
                    op_b_d   = op_b_arr[win_idx];
                    grant_d  = win_idx;
                    rr_ptr_d = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + IW'(1);
                    cnt_d    = 4'(FPU_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // The counter hits zero on this edge: the FPU result is valid now.
                if (cnt_q == 4'd1) begin
                    rsp_data_d   = fpu_data_in;
                    rsp_status_d = fpu_status_in;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign fpu_op_a_out   = op_a_q;
    assign fpu_op_b_out   = op_b_q;
    assign rsp_data_out   = rsp_data_q;
    assign rsp_status_out = rsp_status_q;
    assign busy_out       = (state_q != IDLE);
    assign grant_id_out   = grant_q;

`ifdef FPU_ARB_STICKY_FLAGS_EN
    logic [2:0] sticky_q, sticky_d;

    // A RESP in the same cycle as a clear still contributes its flags.
    always_comb begin
        sticky_d = sticky_clr_in ? 3'b000 : sticky_q;
        if (state_q == RESP)
            sticky_d = sticky_d | rsp_status_q[3:1];
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) sticky_q <= '0;
        else       sticky_q <= sticky_d;
    end

    assign sticky_flags_out = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter (N_REQ=4, FPU_LAT=2) with a simple adder FPU model.
module tb_fpu_arbiter;
    localparam int N_REQ   = 4;
    localparam int FPU_LAT = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N_REQ-1:0]     req_valid_in = '0;
    logic [32*N_REQ-1:0]  req_op_a_in = '0;
    logic [32*N_REQ-1:0]  req_op_b_in = '0;
    logic [N_REQ-1:0]     req_ready_out;
    logic [N_REQ-1:0]     rsp_valid_out;
    logic [31:0]          rsp_data_out;
    logic [3:0]           rsp_status_out;
    logic [31:0]          fpu_op_a_out;
    logic [31:0]          fpu_op_b_out;
    logic [31:0]          fpu_data_in;
    logic [3:0]           fpu_status_in;
    logic                 busy_out;
    logic [1:0]           grant_id_out;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    logic                 sticky_clr_in = 1'b0;
    logic [2:0]           sticky_flags_out;
`endif

    logic [31:0] fpu_pipe = '0;
    logic [3:0]  tb_status = 4'b0001;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit multi_hot = 0;
    int grant_idx[$];
    int grant_cyc[$];
    int rsp_idx[$];

    fpu_arbiter #(.N_REQ(N_REQ), .FPU_LAT(FPU_LAT)) dut (
        .clock100KHz    (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_op_a_in    (req_op_a_in),
        .req_op_b_in    (req_op_b_in),
        .req_ready_out  (req_ready_out),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_data_out   (rsp_data_out),
        .rsp_status_out (rsp_status_out),
        .fpu_op_a_out   (fpu_op_a_out),
        .fpu_op_b_out   (fpu_op_b_out),
        .fpu_data_in    (fpu_data_in),
        .fpu_status_in  (fpu_status_in),
`ifdef FPU_ARB_STICKY_FLAGS_EN
        .sticky_clr_in    (sticky_clr_in),
        .sticky_flags_out (sticky_flags_out),
`endif
        .busy_out       (busy_out),
        .grant_id_out   (grant_id_out)
    );

    always #5 clk = ~clk;

    // FPU model: sum appears one cycle after the operands, valid by the capture edge.
    always @(posedge clk) fpu_pipe <= fpu_op_a_out + fpu_op_b_out;
    assign fpu_data_in   = fpu_pipe;
    assign fpu_status_in = tb_status;

    always @(posedge clk) begin
        if (!reset) begin
            if ($countones(req_ready_out) > 1) multi_hot = 1;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid_in[i] && req_ready_out[i]) begin
                    grant_idx.push_back(i);
                    grant_cyc.push_back(cyc);
                end
                if (rsp_valid_out[i]) rsp_idx.push_back(i);
            end
        end
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_op_a_in[32*idx +: 32] = a;
        req_op_b_in[32*idx +: 32] = b;
    endtask

    task automatic do_reset(input logic [N_REQ-1:0] valid_during);
        step();
        reset = 1'b1;
        req_valid_in = valid_during;
        step();
        grant_idx.delete();
        grant_cyc.delete();
        rsp_idx.delete();
        multi_hot = 0;
        reset = 1'b0;
    endtask

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input logic [3:0] exp_status);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1) << idx;
        set_ops(idx, a, b);
        req_valid_in = oh;
        #1;
        check_eq("ready_at_T", 32'(req_ready_out), 32'(oh));
        step();
        req_valid_in = '0;
        check_eq("fpu_op_a_T1", fpu_op_a_out, a);
        check_eq("fpu_op_b_T1", fpu_op_b_out, b);
        check_eq("busy_T1", 32'(busy_out), 32'd1);
        check_eq("grant_id_T1", 32'(grant_id_out), 32'(idx));
        check_eq("rsp_valid_T1", 32'(rsp_valid_out), 32'd0);
        step();
        check_eq("rsp_valid_T2", 32'(rsp_valid_out), 32'd0);
        step();
        check_eq("rsp_valid_T3", 32'(rsp_valid_out), 32'(oh));
        check_eq("rsp_data_T3", rsp_data_out, exp_data);
        check_eq("rsp_status_T3", 32'(rsp_status_out), 32'(exp_status));
        check_eq("busy_T3", 32'(busy_out), 32'd1);
        step();
        check_eq("busy_T4", 32'(busy_out), 32'd0);
        check_eq("rsp_valid_T4", 32'(rsp_valid_out), 32'd0);
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        // Reset state, with requests present to show ready is held low.
        req_valid_in = 4'b1111;
        step();
        check_eq("rst_ready", 32'(req_ready_out), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
        check_eq("rst_rsp_data", rsp_data_out, 32'd0);
        check_eq("rst_rsp_status", 32'(rsp_status_out), 32'd0);
        check_eq("rst_fpu_op_a", fpu_op_a_out, 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id_out), 32'd0);

        // Single request from requester 1.
        do_reset('0);
        tb_status = 4'b0001;
        run_op(1, 32'h0200_0010, 32'h0200_0020, 32'h0400_0030, 4'b0001);

        // All four valid from reset: order 0,1,2,3,0 spaced FPU_LAT+2 apart.
        do_reset(4'b1111);
        for (int i = 0; i < 22; i++) step();
        check_eq("all4_ngrants_ge5", 32'(grant_idx.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("all4_grant%0d", i), 32'(q_at(grant_idx, i)), 32'(i % 4));
            if (i > 0)
                check_eq($sformatf("all4_gap%0d", i),
                         32'(q_at(grant_cyc, i) - q_at(grant_cyc, i-1)), 32'(FPU_LAT + 2));
        end
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("all4_rsp%0d", i), 32'(q_at(rsp_idx, i)), 32'(i));
        check_eq("all4_ready_onehot", 32'(multi_hot), 32'd0);

        // Requesters 0 and 2 only: alternate 0,2,0,2.
        do_reset(4'b0101);
        for (int i = 0; i < 17; i++) step();
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("alt_grant%0d", i), 32'(q_at(grant_idx, i)), 32'((i % 2) * 2));
        check_eq("alt_ready_onehot", 32'(multi_hot), 32'd0);

        // Reset pulse one cycle after acceptance discards the operation.
        do_reset('0);
        set_ops(1, 32'h1111_0000, 32'h0000_2222);
        req_valid_in = 4'b0010;
        step();
        req_valid_in = '0;
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy_out), 32'd0);
        check_eq("midrst_fpu_op_a", fpu_op_a_out, 32'd0);
        check_eq("midrst_grant_id", 32'(grant_id_out), 32'd0);
        check_eq("midrst_rsp_valid", 32'(rsp_valid_out), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("midrst_no_rsp", 32'(rsp_idx.size()), 32'd0);
        req_valid_in = 4'b1111;
        #1;
        check_eq("midrst_next_ready", 32'(req_ready_out), 32'b0001);
        req_valid_in = '0;

        // Status passthrough and sticky flag accumulation.
        do_reset('0);
        tb_status = 4'b0110;
        run_op(0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0110);
`ifdef FPU_ARB_STICKY_FLAGS_EN
        check_eq("sticky_after1", 32'(sticky_flags_out), 32'b011);
`endif
        tb_status = 4'b1000;
        run_op(2, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 4'b1000);
`ifdef FPU_ARB_STICKY_FLAGS_EN
        check_eq("sticky_after2", 32'(sticky_flags_out), 32'b111);
        sticky_clr_in = 1'b1;
        step();
        sticky_clr_in = 1'b0;
        check_eq("sticky_cleared", 32'(sticky_flags_out), 32'b000);
`endif
        tb_status = 4'b0001;

        // Requester 3 pulses valid while busy and then withdraws.
        do_reset('0);
        set_ops(0, 32'h0000_0005, 32'h0000_0006);
        req_valid_in = 4'b0001;
        step();
        req_valid_in = 4'b1000;
        step();
        req_valid_in = '0;
        for (int i = 0; i < 5; i++) step();
        check_eq("drop3_ngrants", 32'(grant_idx.size()), 32'd1);
        check_eq("drop3_grant0", 32'(q_at(grant_idx, 0)), 32'd0);
        check_eq("drop3_nrsp", 32'(rsp_idx.size()), 32'd1);
        check_eq("drop3_rsp0", 32'(q_at(rsp_idx, 0)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
